// File: rtl/debounce_pkg.sv
// Shared defaults and limits for the pushbutton debouncer array.
package debounce_pkg;

  localparam int DEF_NUM_CH     = 4;
  localparam int DEF_TICK_DIV   = 250000;
  localparam int DEF_STABLE_CNT = 3;
  localparam int DEF_HOLD_TICKS = 400;
  localparam int MAX_STABLE_CNT = 15;
  localparam int MAX_NUM_CH     = 32;

endpackage

// File: rtl/debounce_if.sv
// Bundle of the debouncer-array button inputs and event outputs.
// Handshake: none; pb is level-sampled, press/rel/hold are single-cycle strobes, tick marks the sample slot.
interface debounce_if #(
  parameter int NUM_CH = 4
);
  logic [NUM_CH-1:0] pb;
  logic [NUM_CH-1:0] level;
  logic [NUM_CH-1:0] press;
  logic [NUM_CH-1:0] rel;
  logic [NUM_CH-1:0] hold;
  logic              tick;

  modport master (output pb, input level, press, rel, hold, tick);
  modport slave  (input pb, output level, press, rel, hold, tick);
endinterface

// File: rtl/debounce_chan.sv
// One debounced channel: 2-flop synchronizer, stability counter, edge pulses
// and long-press detection, all advancing only on the shared sample tick.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int STABLE_CNT = DEF_STABLE_CNT,
  parameter int HOLD_TICKS = DEF_HOLD_TICKS
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic tick,
  input  logic pb_raw,
  output logic level,
  output logic press,
  output logic rel,
  output logic hold
);

  localparam int DW = $clog2(STABLE_CNT + 1);
  localparam int HW = $clog2(HOLD_TICKS + 1);

  logic          sync1_q, sync2_q;
  logic [DW-1:0] diff_q, diff_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;
  logic          hold_q, hold_d;

  always_comb begin
    diff_d  = diff_q;
    level_d = level_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    if (tick) begin
      if (sync2_q != level_q) begin
        if (diff_q + DW'(1) == DW'(STABLE_CNT)) begin
          level_d = ~level_q;
          diff_d  = '0;
          press_d = ~level_q;
          rel_d   = level_q;
        end else begin
          diff_d = diff_q + DW'(1);
        end
      end else begin
        diff_d = '0;
      end
    end
  end

  // Hold counting keys off the registered level, so the accepting tick never counts.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    hold_d     = 1'b0;
    if (!level_q) begin
      hold_cnt_d = '0;
    end else if (tick && hold_cnt_q != HW'(HOLD_TICKS)) begin
      hold_cnt_d = hold_cnt_q + HW'(1);
      hold_d     = (hold_cnt_q == HW'(HOLD_TICKS - 1));
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      diff_q     <= '0;
      hold_cnt_q <= '0;
      level_q    <= 1'b0;
      press_q    <= 1'b0;
      rel_q      <= 1'b0;
      hold_q     <= 1'b0;
    end else begin
      sync1_q    <= pb_raw;
      sync2_q    <= sync1_q;
      diff_q     <= diff_d;
      hold_cnt_q <= hold_cnt_d;
      level_q    <= level_d;
      press_q    <= press_d;
      rel_q      <= rel_d;
      hold_q     <= hold_d;
    end
  end

  assign level = level_q;
  assign press = press_q;
  assign rel   = rel_q;
  assign hold  = hold_q;

endmodule

// File: rtl/debounce_array.sv
// Array of independent pushbutton debouncers sharing one sample-tick generator.
module debounce_array
  import debounce_pkg::*;
#(
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int TICK_DIV   = DEF_TICK_DIV,
  parameter int STABLE_CNT = DEF_STABLE_CNT,
  parameter int HOLD_TICKS = DEF_HOLD_TICKS
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] pb_in,
  output logic [NUM_CH-1:0] level_out,
  output logic [NUM_CH-1:0] press_pulse,
  output logic [NUM_CH-1:0] release_pulse,
  output logic [NUM_CH-1:0] hold_pulse,
  output logic              tick_out
);

  localparam int TW = $clog2(TICK_DIV);

  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          tick;

  assign tick = (tick_cnt_q == TW'(TICK_DIV - 1));

  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) tick_cnt_q <= '0;
    else        tick_cnt_q <= tick_cnt_d;
  end

  assign tick_out = tick;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    debounce_chan #(
      .STABLE_CNT (STABLE_CNT),
      .HOLD_TICKS (HOLD_TICKS)
    ) u_chan (
      .clk_in (clk_in),
      .rst_n  (rst_n),
      .tick   (tick),
      .pb_raw (pb_in[i]),
      .level  (level_out[i]),
      .press  (press_pulse[i]),
      .rel    (release_pulse[i]),
      .hold   (hold_pulse[i])
    );
  end

endmodule

// File: tb/tb_debounce_array.sv
// Directed bench for debounce_array with NUM_CH=2, TICK_DIV=4, STABLE_CNT=3, HOLD_TICKS=5.
// Cycle numbers count rising edges since the last reset release.
module tb_debounce_array;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_bad;

  debounce_if #(.NUM_CH(2)) dif ();

  debounce_array #(
    .NUM_CH     (2),
    .TICK_DIV   (4),
    .STABLE_CNT (3),
    .HOLD_TICKS (5)
  ) dut (
    .clk_in        (clk),
    .rst_n         (rst_n),
    .pb_in         (dif.pb),
    .level_out     (dif.level),
    .press_pulse   (dif.press),
    .release_pulse (dif.rel),
    .hold_pulse    (dif.hold),
    .tick_out      (dif.tick)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // event recorder, sampled 2 time units after each rising edge
  int         tick_first, tick_second;
  int         press_n[2], press_hi[2], press_at[2];
  int         rel_n[2], rel_hi[2], rel_at[2];
  int         hold_n[2], hold_hi[2], hold_at[2];
  int         rise_at[2];
  int         both_at;
  int         clash_n;
  logic [1:0] prev_level, prev_press, prev_rel, prev_hold;

  initial begin
    tick_first = -1; tick_second = -1; both_at = -1; clash_n = 0;
    for (int ch = 0; ch < 2; ch++) begin
      press_n[ch] = 0; press_hi[ch] = 0; press_at[ch] = -1;
      rel_n[ch] = 0; rel_hi[ch] = 0; rel_at[ch] = -1;
      hold_n[ch] = 0; hold_hi[ch] = 0; hold_at[ch] = -1;
      rise_at[ch] = -1;
    end
  end

  always @(posedge clk) begin
    #2;
    if (!rst_n) begin
      tick_first = -1;
      tick_second = -1;
      prev_level = '0; prev_press = '0; prev_rel = '0; prev_hold = '0;
    end else begin
      if (dif.tick) begin
        if (tick_first < 0) tick_first = cyc;
        else if (tick_second < 0) tick_second = cyc;
      end
      for (int ch = 0; ch < 2; ch++) begin
        if (dif.press[ch]) begin
          press_hi[ch]++;
          if (!prev_press[ch]) begin press_n[ch]++; press_at[ch] = cyc; end
        end
        if (dif.rel[ch]) begin
          rel_hi[ch]++;
          if (!prev_rel[ch]) begin rel_n[ch]++; rel_at[ch] = cyc; end
        end
        if (dif.hold[ch]) begin
          hold_hi[ch]++;
          if (!prev_hold[ch]) begin hold_n[ch]++; hold_at[ch] = cyc; end
        end
        if (dif.level[ch] && !prev_level[ch]) rise_at[ch] = cyc;
        if (dif.press[ch] && dif.rel[ch]) clash_n++;
      end
      if (dif.press == 2'b11) both_at = cyc;
      prev_level = dif.level; prev_press = dif.press;
      prev_rel = dif.rel; prev_hold = dif.hold;
    end
  end

  // scoreboard check
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_bad    = 0;
    rst_n    = 1'b0;
    dif.pb   = 2'b00;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_level", 32'(dif.level), 0);
    check_eq("rst_pulses", 32'({dif.press, dif.rel, dif.hold}), 0);
    check_eq("rst_tick", 32'(dif.tick), 0);
    rst_n = 1'b1;

    // idle: tick cadence, nothing else moves
    wait_cyc(20);
    check_eq("tick_first", tick_first, 3);
    check_eq("tick_period", tick_second - tick_first, 4);
    check_eq("idle_level", 32'(dif.level), 0);
    check_eq("idle_events", press_n[0] + press_n[1] + rel_n[0] + rel_n[1] + hold_n[0] + hold_n[1], 0);

    // press ch0 at cycle 20: accept on tick edges 24/28/32
    dif.pb = 2'b01;
    wait_cyc(31);
    check_eq("pre_accept_level", 32'(dif.level), 0);
    wait_cyc(33);
    check_eq("rise_at0", rise_at[0], 32);
    check_eq("press_at0", press_at[0], 32);
    check_eq("press_n0", press_n[0], 1);
    check_eq("press_width0", press_hi[0], 1);
    check_eq("level_ch0_only", 32'(dif.level), 32'd1);
    check_eq("press_n1_idle", press_n[1], 0);

    // long press: hold on 5th tick after accept, then release at cycle 72
    wait_cyc(72);
    check_eq("hold_n0", hold_n[0], 1);
    check_eq("hold_at0", hold_at[0], 52);
    check_eq("hold_width0", hold_hi[0], 1);
    dif.pb = 2'b00;
    wait_cyc(90);
    check_eq("rel_at0", rel_at[0], 84);
    check_eq("rel_n0", rel_n[0], 1);
    check_eq("rel_width0", rel_hi[0], 1);
    check_eq("hold_once0", hold_n[0], 1);

    // glitch lasting two ticks must be rejected
    wait_cyc(100);
    dif.pb = 2'b01;
    wait_cyc(106);
    dif.pb = 2'b00;
    wait_cyc(120);
    check_eq("glitch_level", 32'(dif.level), 0);
    check_eq("glitch_press", press_n[0], 1);
    check_eq("glitch_rel", rel_n[0], 1);

    // fresh press needs the full three ticks again (diff counter cleared)
    dif.pb = 2'b01;
    wait_cyc(136);
    check_eq("diff_cleared_press_at", press_at[0], 132);
    dif.pb = 2'b00;
    wait_cyc(156);
    check_eq("short_rel_at0", rel_at[0], 148);
    check_eq("short_no_hold", hold_n[0], 1);

    // both channels together
    wait_cyc(160);
    dif.pb = 2'b11;
    wait_cyc(176);
    check_eq("both_at", both_at, 172);
    check_eq("press_n1", press_n[1], 1);
    check_eq("press_n0_total", press_n[0], 3);
    check_eq("clash", clash_n, 0);

    // reset mid-hold, button kept down across release
    wait_cyc(186);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_level", 32'(dif.level), 0);
    check_eq("midrst_pulses", 32'({dif.press, dif.rel, dif.hold}), 0);
    repeat (3) @(negedge clk);
    check_eq("midrst_no_hold", hold_n[0] + hold_n[1], 1);
    rst_n = 1'b1;
    wait_cyc(13);
    check_eq("tick_after_rst", tick_first, 3);
    check_eq("repress_both_at", both_at, 12);
    check_eq("repress_at1", press_at[1], 12);
    check_eq("repress_level", 32'(dif.level), 32'd3);
    check_eq("press_width_all", press_hi[0] + press_hi[1], press_n[0] + press_n[1]);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
